// File: rtl/vscale_dmem_responder.sv
// rtl/vscale_dmem_responder.sv - dmem responder: wait-state FSM over a byte-lane scratchpad
module vscale_dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_en,
    input  logic        dmem_wen,
    input  logic [2:0]  dmem_size,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata_delayed,
    output logic [31:0] dmem_rdata,
    output logic        dmem_wait,
    output logic        dmem_badmem_e
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam logic [7:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 8'd0 : 8'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DATA} state_t;

    state_t      state;
    logic [7:0]  count;
    logic        req_wen;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] mem [DEPTH_WORDS];

    function automatic logic is_fault(input logic [2:0] size, input logic [31:0] addr);
        logic [32:0] off;
        off = {1'b0, addr} - {1'b0, BASE_ADDR};
        return (size[1:0] == 2'd3) || (size == 3'd6) ||
               (size[1:0] == 2'd1 && addr[0]) ||
               (size[1:0] == 2'd2 && addr[1:0] != 2'd0) ||
               (off >= SPAN);
    endfunction

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return AW'(off >> 2);
    endfunction

    function automatic logic [3:0] lane_enables(input logic [2:0] size, input logic [31:0] addr);
        case (size[1:0])
            2'd0:    return 4'b0001 << addr[1:0];
            2'd1:    return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] size, input logic [31:0] wd);
        case (size[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] extract(input logic [2:0] size, input logic [31:0] addr,
                                            input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {addr[1:0], 3'b000};
        case (size[1:0])
            2'd0:    return size[2] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'd1:    return size[2] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    logic          accept;
    logic          nxt_wen;
    logic [2:0]    nxt_size;
    logic [31:0]   nxt_addr;
    logic          nxt_fault;
    logic [AW-1:0] nxt_idx;
    logic [AW-1:0] cur_idx;
    logic [3:0]    cur_be;
    logic [31:0]   cur_lanes;
    logic          commit;
    logic [31:0]   merged;
    logic [31:0]   load_data;

    // The request entering DATA is either the one being accepted (zero wait) or the latched one.
    assign accept    = dmem_en && (state != WAIT);
    assign nxt_wen   = accept ? dmem_wen  : req_wen;
    assign nxt_size  = accept ? dmem_size : req_size;
    assign nxt_addr  = accept ? dmem_addr : req_addr;
    assign nxt_fault = is_fault(nxt_size, nxt_addr);
    assign nxt_idx   = word_index(nxt_addr);
    assign cur_idx   = word_index(req_addr);
    assign cur_be    = lane_enables(req_size, req_addr);
    assign cur_lanes = lane_data(req_size, dmem_wdata_delayed);
    assign commit    = (state == DATA) && req_wen && !dmem_badmem_e && !reset;

    // Forward bytes of a store committing on this edge into the load being captured.
    always_comb begin
        merged = mem[nxt_idx];
        if (commit && cur_idx == nxt_idx) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) merged[8*i +: 8] = cur_lanes[8*i +: 8];
            end
        end
    end

    assign load_data = (nxt_wen || nxt_fault) ? 32'h0 : extract(nxt_size, nxt_addr, merged);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            count         <= 8'd0;
            req_wen       <= 1'b0;
            req_size      <= 3'd0;
            req_addr      <= 32'h0;
            dmem_wait     <= 1'b0;
            dmem_badmem_e <= 1'b0;
            dmem_rdata    <= 32'h0;
        end else if (accept) begin
            req_wen  <= dmem_wen;
            req_size <= dmem_size;
            req_addr <= dmem_addr;
            if (WAIT_CYCLES == 0) begin
                state         <= DATA;
                dmem_wait     <= 1'b0;
                dmem_badmem_e <= nxt_fault;
                dmem_rdata    <= load_data;
            end else begin
                state         <= WAIT;
                count         <= WAIT_INIT;
                dmem_wait     <= 1'b1;
                dmem_badmem_e <= 1'b0;
                dmem_rdata    <= 32'h0;
            end
        end else begin
            case (state)
                WAIT: begin
                    if (count == 8'd0) begin
                        state         <= DATA;
                        dmem_wait     <= 1'b0;
                        dmem_badmem_e <= nxt_fault;
                        dmem_rdata    <= load_data;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                DATA: begin
                    state         <= IDLE;
                    dmem_wait     <= 1'b0;
                    dmem_badmem_e <= 1'b0;
                    dmem_rdata    <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) mem[cur_idx][8*i +: 8] <= cur_lanes[8*i +: 8];
            end
        end
    end
endmodule
